instr_stream_gen: RTL and testbench

Transmit side of the experiment FSM instruction bus. It accepts 32-bit CPU words of the form {repeat, instr} and buffers them in an internal FIFO. It expands each word into repeat+1 back-to-back beats on the 16-bit instruction AXI-stream, and raises `halt` once the loaded program is fully drained. It sits between the CPU bus bridge and the experiment FSM's `instr_axis_*`/`halt` inputs.

---
 rtl/instr_stream_gen.sv | 214 +++++++++++++++++++++
 tb/tb_instr_stream_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_gen.sv
// instr_stream_gen: transmit side of the experiment FSM instruction bus.
// Buffers 32-bit CPU words {repeat, instr} in a FIFO and expands each word
// into repeat+1 back-to-back beats on a 16-bit AXI-stream. Raises halt once a
// program marked by load_done has fully drained.
//
// Optional feature macro: ISING_INSTR_REPEAT_EN
//   defined   : cpu_tdata[31:16] sets the repeat count of each word.
//   undefined : repeat field ignored, every word yields exactly one beat.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cpu_tdata/tvalid   CPU word in, {repeat[31:16], instr[15:0]}
//   cpu_tready         combinational FIFO space available (0 in reset/flush)
//   load_done          pulse marking the end of the loaded program
//   flush              synchronous clear of FIFO, output stage, flags, counter
//   instr_axis_*       16-bit instruction stream to the experiment FSM
//   halt               program end committed and fully drained (sticky)
//   fill_level         FIFO occupancy, output stage excluded
//   underrun           sticky starvation flag mid-program
//   issued_count       handshaked beats since reset/flush (wraps)
module instr_stream_gen #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   cpu_tdata,
  input  logic                          cpu_tvalid,
  output logic                          cpu_tready,
  input  logic                          load_done,
  input  logic                          flush,
  output logic [15:0]                   instr_axis_tdata,
  output logic                          instr_axis_tvalid,
  input  logic                          instr_axis_tready,
  output logic                          halt,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          underrun,
  output logic [CNT_W-1:0]              issued_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = AW + 1;

  typedef struct packed {
    logic [15:0] rep;
    logic [15:0] instr;
  } cpu_word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_EMIT  = 1'b1
  } state_e;

  cpu_word_t         mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  state_e            state_q, state_d;
  logic [15:0]       tdata_q, tdata_d;
  logic [15:0]       rem_q, rem_d;
  logic              prog_end_q, prog_end_d;
  logic              halt_q, halt_d;
  logic              underrun_q, underrun_d;
  logic              issued_any_q, issued_any_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  cpu_word_t         head;
  logic [15:0]       rem_load;
  logic              fifo_nempty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              hs;
  logic              beat_cnt;

  assign head        = mem[rd_ptr_q];
  assign fifo_nempty = (fill_q != '0);
  assign fifo_full   = (fill_q == FW'(FIFO_DEPTH));
  assign cpu_tready  = !rst && !flush && !fifo_full;
  assign push        = cpu_tvalid && cpu_tready;
  assign hs          = (state_q == ST_EMIT) && instr_axis_tready;
  assign beat_cnt    = hs && !flush;

`ifdef ISING_INSTR_REPEAT_EN
  assign rem_load = head.rep;
`else
  // Repeat field is stored but never consumed in this build.
  logic unused_rep;
  assign unused_rep = ^head.rep;
  assign rem_load   = '0;
`endif

  // Output stage: load on empty, count down repeats, reload with no bubble.
  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      tdata_d = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (fifo_nempty) begin
            pop     = 1'b1;
            tdata_d = head.instr;
            rem_d   = rem_load;
            state_d = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (hs) begin
            if (rem_q != '0) begin
              rem_d = rem_q - 16'd1;
            end else if (fifo_nempty) begin
              pop     = 1'b1;
              tdata_d = head.instr;
              rem_d   = rem_load;
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop on the same edge cancel.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   fill_d = fill_q + FW'(1);
        2'b01:   fill_d = fill_q - FW'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // Flags and beat counter; flush wins over load_done and a same-cycle beat.
  always_comb begin
    prog_end_d   = prog_end_q;
    halt_d       = halt_q;
    underrun_d   = underrun_q;
    issued_any_d = issued_any_q;
    cnt_d        = cnt_q;
    if (flush) begin
      prog_end_d   = 1'b0;
      halt_d       = 1'b0;
      underrun_d   = 1'b0;
      issued_any_d = 1'b0;
      cnt_d        = '0;
    end else begin
      prog_end_d   = prog_end_q || load_done;
      halt_d       = halt_q || (prog_end_q && !fifo_nempty && (state_q == ST_EMPTY));
      underrun_d   = underrun_q || (instr_axis_tready && (state_q == ST_EMPTY) &&
                                    !prog_end_q && issued_any_q);
      issued_any_d = issued_any_q || beat_cnt;
      if (beat_cnt) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // FIFO storage (no reset needed, guarded by pointers).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cpu_word_t'(cpu_tdata);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      state_q      <= ST_EMPTY;
      tdata_q      <= '0;
      rem_q        <= '0;
      prog_end_q   <= 1'b0;
      halt_q       <= 1'b0;
      underrun_q   <= 1'b0;
      issued_any_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      state_q      <= state_d;
      tdata_q      <= tdata_d;
      rem_q        <= rem_d;
      prog_end_q   <= prog_end_d;
      halt_q       <= halt_d;
      underrun_q   <= underrun_d;
      issued_any_q <= issued_any_d;
      cnt_q        <= cnt_d;
    end
  end

  assign instr_axis_tdata  = tdata_q;
  assign instr_axis_tvalid = (state_q == ST_EMIT);
  assign halt              = halt_q;
  assign fill_level        = fill_q;
  assign underrun          = underrun_q;
  assign issued_count      = cnt_q;

endmodule

// File: tb/tb_instr_stream_gen.sv
// Directed testbench for instr_stream_gen; expectations follow the build's
// ISING_INSTR_REPEAT_EN setting.
module tb_instr_stream_gen;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 32;
  localparam int unsigned FLW   = $clog2(DEPTH) + 1;
`ifdef ISING_INSTR_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     cpu_tdata = '0;
  logic            cpu_tvalid = 1'b0;
  logic            cpu_tready;
  logic            load_done = 1'b0;
  logic            flush = 1'b0;
  logic [15:0]     instr_axis_tdata;
  logic            instr_axis_tvalid;
  logic            instr_axis_tready = 1'b0;
  logic            halt;
  logic [FLW-1:0]  fill_level;
  logic            underrun;
  logic [CW-1:0]   issued_count;

  int checks = 0;
  int errors = 0;

  instr_stream_gen #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_tdata         (cpu_tdata),
    .cpu_tvalid        (cpu_tvalid),
    .cpu_tready        (cpu_tready),
    .load_done         (load_done),
    .flush             (flush),
    .instr_axis_tdata  (instr_axis_tdata),
    .instr_axis_tvalid (instr_axis_tvalid),
    .instr_axis_tready (instr_axis_tready),
    .halt              (halt),
    .fill_level        (fill_level),
    .underrun          (underrun),
    .issued_count      (issued_count)
  );

  always #5 clk = ~clk;

  // Beat monitor on the falling edge: records handshakes, halt timing and
  // tdata changes while stalled.
  int          cyc = 0;
  logic [15:0] beat_q[$];
  int          beat_cyc[$];
  int          halt_cyc = -1;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst || flush) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && instr_axis_tvalid && (instr_axis_tdata !== prev_data))
        stab_err = stab_err + 1;
      if (instr_axis_tvalid && instr_axis_tready) begin
        beat_q.push_back(instr_axis_tdata);
        beat_cyc.push_back(cyc);
      end
      if (halt && halt_cyc < 0) halt_cyc = cyc;
      prev_stall = instr_axis_tvalid && !instr_axis_tready;
      prev_data  = instr_axis_tdata;
    end
  end

  function automatic int nbeats(input logic [15:0] r);
    return REP_EN ? (32'(r) + 1) : 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    beat_q.delete();
    beat_cyc.delete();
    halt_cyc = -1;
    stab_err = 0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    clear_mon();
  endtask

  task automatic write_word(input logic [31:0] w);
    bit ok = 1'b0;
    cpu_tdata  = w;
    cpu_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cpu_tready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++; errors++;
      $display("FAIL write_timeout: word %h never accepted", w);
    end
    cpu_tvalid = 1'b0;
  endtask

  task automatic wait_tvalid(input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n && !seen; i++) begin
      if (instr_axis_tvalid) seen = 1'b1;
      else tick(1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tvalid_timeout: tvalid got 0 expected 1 within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (instr_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", instr_axis_tvalid); end
    checks++; if (cpu_tready !== 1'b0) begin errors++; $display("FAIL rst_cpu_tready: got %b expected 0", cpu_tready); end
    checks++; if (issued_count !== '0) begin errors++; $display("FAIL rst_issued: got %0d expected 0", issued_count); end
    checks++; if ({halt, underrun} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {halt, underrun}); end
    rst = 1'b0;
    tick(1);
    checks++; if (cpu_tready !== 1'b1) begin errors++; $display("FAIL post_rst_cpu_tready: got %b expected 1", cpu_tready); end
    checks++; if (fill_level !== '0) begin errors++; $display("FAIL post_rst_fill: got %0d expected 0", fill_level); end
  endtask

  task automatic test_program();
    logic [15:0] exp[$];
    int last;
    flush_pulse();
    instr_axis_tready = 1'b1;
    write_word({16'd0, 16'h0003});
    write_word({16'd2, 16'h0011});
    write_word({16'd0, 16'h0200});
    load_done = 1'b1;
    tick(1);
    load_done = 1'b0;
    tick(12);
    exp.push_back(16'h0003);
    for (int i = 0; i < nbeats(16'd2); i++) exp.push_back(16'h0011);
    exp.push_back(16'h0200);
    checks++; if (beat_q.size() != exp.size()) begin errors++; $display("FAIL prog_beats: got %0d expected %0d", beat_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= beat_q.size() || beat_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL prog_beat%0d: got %h expected %h", i, (i < beat_q.size()) ? beat_q[i] : 16'hxxxx, exp[i]);
      end
    end
    last = (beat_cyc.size() > 0) ? beat_cyc[beat_cyc.size()-1] : -100;
    checks++; if (beat_cyc.size() > 0 && (last - beat_cyc[0]) != exp.size() - 1) begin errors++; $display("FAIL prog_consecutive: got span %0d expected %0d", last - beat_cyc[0], exp.size() - 1); end
    checks++; if (halt_cyc != last + 2) begin errors++; $display("FAIL prog_halt_time: got cycle %0d expected %0d", halt_cyc, last + 2); end
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL prog_halt: got %b expected 1", halt); end
    checks++; if (issued_count !== CW'(exp.size())) begin errors++; $display("FAIL prog_issued: got %0d expected %0d", issued_count, exp.size()); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL prog_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_full();
    flush_pulse();
    instr_axis_tready = 1'b0;
    for (int i = 0; i < 17; i++) write_word({16'd0, 16'(32'h1000 + i)});
    checks++; if (cpu_tready !== 1'b0) begin errors++; $display("FAIL full_cpu_tready: got %b expected 0", cpu_tready); end
    checks++; if (fill_level !== FLW'(16)) begin errors++; $display("FAIL full_fill: got %0d expected 16", fill_level); end
    checks++; if ({instr_axis_tvalid, instr_axis_tdata} !== {1'b1, 16'h1000}) begin errors++; $display("FAIL full_head: got %b/%h expected 1/1000", instr_axis_tvalid, instr_axis_tdata); end
    tick(3);
    checks++; if (stab_err != 0 || beat_q.size() != 0) begin errors++; $display("FAIL full_stall: got %0d changes %0d beats expected 0 0", stab_err, beat_q.size()); end
    instr_axis_tready = 1'b1;
    tick(25);
    instr_axis_tready = 1'b0;
    checks++; if (beat_q.size() != 17) begin errors++; $display("FAIL full_drain_count: got %0d expected 17", beat_q.size()); end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (i >= beat_q.size() || beat_q[i] !== 16'(32'h1000 + i)) begin
        errors++;
        $display("FAIL full_order%0d: got %h expected %h", i, (i < beat_q.size()) ? beat_q[i] : 16'hxxxx, 16'(32'h1000 + i));
      end
    end
    checks++; if (fill_level !== '0) begin errors++; $display("FAIL full_drained_fill: got %0d expected 0", fill_level); end
  endtask

  task automatic test_toggle();
    flush_pulse();
    instr_axis_tready = 1'b0;
    write_word({16'd3, 16'h0081});
    wait_tvalid(5);
    for (int i = 0; i < 12; i++) begin
      instr_axis_tready = (i % 2 == 0);
      tick(1);
    end
    instr_axis_tready = 1'b0;
    tick(2);
    checks++; if (beat_q.size() != nbeats(16'd3)) begin errors++; $display("FAIL toggle_count: got %0d expected %0d", beat_q.size(), nbeats(16'd3)); end
    for (int i = 0; i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== 16'h0081) begin errors++; $display("FAIL toggle_data%0d: got %h expected 0081", i, beat_q[i]); end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL toggle_stable: got %0d changes expected 0", stab_err); end
    checks++; if (issued_count !== CW'(nbeats(16'd3))) begin errors++; $display("FAIL toggle_issued: got %0d expected %0d", issued_count, nbeats(16'd3)); end
  endtask

  task automatic test_underrun();
    flush_pulse();
    instr_axis_tready = 1'b1;
    write_word({16'd0, 16'h0055});
    tick(6);
    checks++; if ({underrun, halt} !== 2'b10) begin errors++; $display("FAIL underrun_set: got underrun/halt %b expected 10", {underrun, halt}); end
    checks++; if (issued_count !== CW'(1)) begin errors++; $display("FAIL underrun_issued: got %0d expected 1", issued_count); end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL flush_underrun: got %b expected 0", underrun); end
    checks++; if (issued_count !== '0) begin errors++; $display("FAIL flush_issued: got %0d expected 0", issued_count); end
    checks++; if (fill_level !== '0) begin errors++; $display("FAIL flush_fill: got %0d expected 0", fill_level); end
    instr_axis_tready = 1'b0;
  endtask

  task automatic test_flush_priority();
    flush_pulse();
    instr_axis_tready = 1'b0;
    write_word({16'd0, 16'h0077});
    wait_tvalid(5);
    flush = 1'b1; instr_axis_tready = 1'b1; load_done = 1'b1;
    cpu_tvalid = 1'b1; cpu_tdata = {16'd0, 16'h0066};
    #1;
    checks++; if (cpu_tready !== 1'b0) begin errors++; $display("FAIL fp_cpu_tready: got %b expected 0", cpu_tready); end
    tick(1);
    flush = 1'b0; load_done = 1'b0; cpu_tvalid = 1'b0; instr_axis_tready = 1'b0;
    checks++; if (issued_count !== '0) begin errors++; $display("FAIL fp_issued: got %0d expected 0", issued_count); end
    checks++; if ({instr_axis_tvalid, fill_level} !== {1'b0, FLW'(0)}) begin errors++; $display("FAIL fp_stage: got tvalid %b fill %0d expected 0 0", instr_axis_tvalid, fill_level); end
    tick(4);
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL fp_halt: got %b expected 0", halt); end
    checks++; if (fill_level !== '0 || beat_q.size() != 0) begin errors++; $display("FAIL fp_no_word: got fill %0d beats %0d expected 0 0", fill_level, beat_q.size()); end
  endtask

  task automatic test_async_reset();
    flush_pulse();
    instr_axis_tready = 1'b1;
    write_word({16'd0, 16'h0012});
    tick(4);
    instr_axis_tready = 1'b0;
    write_word({16'd5, 16'h0099});
    wait_tvalid(5);
    checks++; if ({underrun, instr_axis_tdata} !== {1'b1, 16'h0099}) begin errors++; $display("FAIL ar_pre: got %b/%h expected 1/0099", underrun, instr_axis_tdata); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({instr_axis_tvalid, instr_axis_tdata} !== 17'd0) begin errors++; $display("FAIL ar_stage: got %b/%h expected 0/0000", instr_axis_tvalid, instr_axis_tdata); end
    checks++; if ({halt, underrun, cpu_tready} !== 3'b000) begin errors++; $display("FAIL ar_flags: got %b expected 000", {halt, underrun, cpu_tready}); end
    checks++; if (issued_count !== '0 || fill_level !== '0) begin errors++; $display("FAIL ar_counts: got %0d/%0d expected 0/0", issued_count, fill_level); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    instr_axis_tready = 1'b1;
    write_word({16'd0, 16'h0004});
    tick(6);
    checks++; if (beat_q.size() != 1 || beat_q[0] !== 16'h0004) begin errors++; $display("FAIL ar_resume: got %0d beats first %h expected 1 beat 0004", beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 16'hxxxx); end
    checks++; if (issued_count !== CW'(1)) begin errors++; $display("FAIL ar_issued: got %0d expected 1", issued_count); end
  endtask

  task automatic test_repeat_field();
    flush_pulse();
    instr_axis_tready = 1'b1;
    write_word({16'd7, 16'h0002});
    tick(14);
    checks++; if (beat_q.size() != nbeats(16'd7)) begin errors++; $display("FAIL rep_count: got %0d expected %0d", beat_q.size(), nbeats(16'd7)); end
    for (int i = 0; i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== 16'h0002) begin errors++; $display("FAIL rep_data%0d: got %h expected 0002", i, beat_q[i]); end
    end
    checks++; if (issued_count !== CW'(nbeats(16'd7))) begin errors++; $display("FAIL rep_issued: got %0d expected %0d", issued_count, nbeats(16'd7)); end
    instr_axis_tready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program();
    test_full();
    test_toggle();
    test_underrun();
    test_flush_priority();
    test_async_reset();
    test_repeat_field();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
